// File: rtl/spi_master_mc.sv
// SPI master: DATA_W-bit words, NUM_CS active-low selects, CPOL/CPHA modes, MSB/LSB order, CS hold for bursts.
// Optional SPI_LOOPBACK_EN adds loopback_i, which routes mosi_o back into the receive path.
//
// state    | meaning
// IDLE     | waiting for start_i, ready_o=1; a held CS stays low
// CS_GAP   | all selects high for one half-period before switching away from a held CS
// CS_SETUP | selected CS low, sclk at idle level
// CPHA_DLY | extra idle half-period before the first bit when cpha=1
// P0       | first half of a bit; miso sampled at its end
// P1       | second half of a bit; mosi shifted at its end
// CS_HOLD  | CS still low for one half-period after the last bit
module spi_master_mc #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int NUM_CS = 4,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DIV_W-1:0]  dvsr_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic              hold_cs_i,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  input  logic              miso_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              done_tick_o,
  output logic              ready_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_n_o
);

  localparam int NW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CS_GAP, CS_SETUP, CPHA_DLY, P0, P1, CS_HOLD} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  tmr_q, dvsr_q;
  logic [NW-1:0]     n_q;
  logic [DATA_W-1:0] sh_out_q, sh_in_q, dout_q;
  logic [CS_W-1:0]   cs_q, held_idx_q, cs_idx;
  logic              cpol_q, cpha_q, lsb_q, hold_q, held_q, done_q, sclk_q;
  logic              tc, start_acc, sample_en, shift_en, word_done;
  logic              pcpol, pcpha, sclk_d, cs_on, rx;

  assign tc = (tmr_q == '0);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    sample_en = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        start_acc = 1'b1;
        if (held_q && held_idx_q == cs_sel_i) state_d = cpha_i ? CPHA_DLY : P0;
        else if (held_q)                      state_d = CS_GAP;
        else                                  state_d = CS_SETUP;
      end
      CS_GAP:   if (tc) state_d = CS_SETUP;
      CS_SETUP: if (tc) state_d = cpha_q ? CPHA_DLY : P0;
      CPHA_DLY: if (tc) state_d = P0;
      P0: if (tc) begin
        sample_en = 1'b1;
        state_d   = P1;
      end
      P1: if (tc) begin
        if (n_q == NW'(DATA_W - 1)) begin
          word_done = 1'b1;
          state_d   = CS_HOLD;
        end else begin
          shift_en = 1'b1;
          state_d  = P0;
        end
      end
      CS_HOLD:  if (tc) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // The start cycle already drives sclk from the new transfer's mode
    pcpol  = start_acc ? cpol_i : cpol_q;
    pcpha  = start_acc ? cpha_i : cpha_q;
    sclk_d = (((state_d == P1) && !pcpha) || ((state_d == P0) && pcpha)) ^ pcpol;
  end

  always_comb begin
    cs_on  = 1'b1;
    cs_idx = cs_q;
    if (state_q == IDLE) begin
      cs_on  = held_q;
      cs_idx = held_idx_q;
    end else if (state_q == CS_GAP) begin
      cs_on  = 1'b0;
    end
    for (int i = 0; i < NUM_CS; i++)
      cs_n_o[i] = ~(cs_on && (cs_idx == CS_W'(i)));
  end

  assign mosi_o = lsb_q ? sh_out_q[0] : sh_out_q[DATA_W-1];

`ifdef SPI_LOOPBACK_EN
  assign rx = loopback_i ? mosi_o : miso_i;
`else
  assign rx = miso_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      dvsr_q     <= '0;
      n_q        <= '0;
      sh_out_q   <= '0;
      sh_in_q    <= '0;
      dout_q     <= '0;
      cs_q       <= '0;
      held_idx_q <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      hold_q     <= 1'b0;
      held_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      done_q  <= word_done;
      if (start_acc)  tmr_q <= dvsr_i;
      else if (tc)    tmr_q <= dvsr_q;
      else            tmr_q <= tmr_q - DIV_W'(1);
      if (start_acc) begin
        dvsr_q   <= dvsr_i;
        cs_q     <= cs_sel_i;
        cpol_q   <= cpol_i;
        cpha_q   <= cpha_i;
        lsb_q    <= lsb_first_i;
        hold_q   <= hold_cs_i;
        sh_out_q <= din_i;
        n_q      <= '0;
        held_q   <= 1'b0;
      end
      // First received bit lands in the MSB or LSB to match din_i ordering
      if (sample_en)
        sh_in_q <= lsb_q ? {rx, sh_in_q[DATA_W-1:1]} : {sh_in_q[DATA_W-2:0], rx};
      if (shift_en) begin
        sh_out_q <= lsb_q ? {1'b0, sh_out_q[DATA_W-1:1]} : {sh_out_q[DATA_W-2:0], 1'b0};
        n_q      <= n_q + NW'(1);
      end
      if (word_done) dout_q <= sh_in_q;
      if (state_q == CS_HOLD && tc) begin
        held_q     <= hold_q;
        held_idx_q <= cs_q;
      end
    end
  end

  assign dout_o      = dout_q;
  assign done_tick_o = done_q;
  assign ready_o     = (state_q == IDLE);
  assign sclk_o      = sclk_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: SPI slave model on the pins, scoreboard of expected words and timing,
// directed mode/burst/reset cases followed by random transfers.
module tb_spi_master_mc;
  logic       clk_i = 1'b0, reset_i = 1'b1, start_i = 1'b0;
  logic [7:0] din_i = '0;
  logic [15:0] dvsr_i = '0;
  logic [1:0] cs_sel_i = '0;
  logic       cpol_i = 1'b0, cpha_i = 1'b0, lsb_first_i = 1'b0, hold_cs_i = 1'b0, miso_i = 1'b0;
  logic [7:0] dout_o;
  logic       done_tick_o, ready_o, sclk_o, mosi_o;
  logic [3:0] cs_n_o;

  spi_master_mc #(.DATA_W(8), .DIV_W(16), .NUM_CS(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .din_i(din_i), .dvsr_i(dvsr_i),
    .cs_sel_i(cs_sel_i), .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_first_i(lsb_first_i),
    .hold_cs_i(hold_cs_i),
`ifdef SPI_LOOPBACK_EN
    .loopback_i(1'b0),
`endif
    .miso_i(miso_i), .dout_o(dout_o), .done_tick_o(done_tick_o), .ready_o(ready_o),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] din;
    int         acc;
    int         lat;
  } exp_t;
  exp_t sbq[$];

  int vectors = 0, errors = 0, cyc = 0;
  // slave model state
  logic       sv_active = 1'b0, sv_cpol = 1'b0, sv_cpha = 1'b0, sv_lsb = 1'b0, sv_prev = 1'b0;
  logic [7:0] sv_word = '0, sv_cap = '0;
  int         sv_k = 0, sv_first = 0, sv_last = 0, sv_per_err = 0, sv_h = 1;
  // reference CS-hold state
  logic       m_held = 1'b0;
  int         m_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [7:0] w, input int k, input logic lsb);
    return lsb ? w[k] : w[7-k];
  endfunction

  function automatic logic [3:0] sel_mask(input int s);
    logic [3:0] m = 4'hF;
    if (s < 4) m[s] = 1'b0;
    return m;
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Slave: samples mosi and advances miso on the mode's sampling edge
  initial forever begin
    @(negedge clk_i);
    if (sv_active && sclk_o !== sv_prev) begin
      sv_prev = sclk_o;
      if (((sclk_o != sv_cpol) ^ sv_cpha) && sv_k < 8) begin
        if (sv_lsb) sv_cap[sv_k] = mosi_o;
        else        sv_cap[7-sv_k] = mosi_o;
        if (sv_k == 0) sv_first = cyc;
        else if (cyc - sv_last != 2 * sv_h) sv_per_err++;
        sv_last = cyc;
        sv_k++;
        if (sv_k < 8) miso_i = bit_at(sv_word, sv_k, sv_lsb);
      end
    end
  end

  // Monitor: pops the scoreboard on every done tick
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (done_tick_o === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("dout", 32'(dout_o), 32'(e.dout));
        chk("mosi_word", 32'(sv_cap), 32'(e.din));
        chk("sample_count", 32'(sv_k), 32'd8);
        chk("first_sample_latency", 32'(sv_first - e.acc), 32'(e.lat));
        chk("sclk_period", 32'(sv_per_err), 32'd0);
        sv_active = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (ready_o !== 1'b1 && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    if (ready_o !== 1'b1) chk("ready_timeout", 32'(ready_o), 32'd1);
  endtask

  task automatic xfer(input logic [7:0] din, input logic [7:0] sw, input int dvsr, input int sel,
                      input logic cpol, input logic cpha, input logic lsb, input logic hold,
                      input int abort_at);
    int  h = dvsr + 1;
    bit  same = m_held && (m_idx == sel);
    bit  gap  = m_held && !same;
    int  t = 0;
    wait_ready();
    @(negedge clk_i);
    din_i = din; dvsr_i = 16'(dvsr); cs_sel_i = 2'(sel);
    cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb; hold_cs_i = hold;
    start_i = 1'b1;
    miso_i = bit_at(sw, 0, lsb);
    sv_word = sw; sv_lsb = lsb; sv_cpol = cpol; sv_cpha = cpha;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    din_i = 8'($urandom); dvsr_i = 16'($urandom); cs_sel_i = 2'($urandom);
    cpol_i = 1'($urandom); cpha_i = 1'($urandom); lsb_first_i = 1'($urandom);
    hold_cs_i = 1'($urandom);
    sv_prev = cpol; sv_k = 0; sv_per_err = 0; sv_h = h; sv_cap = '0; sv_active = 1'b1;
    sbq.push_back('{dout: sw, din: din, acc: cyc,
                    lat: h * ((gap ? 1 : 0) + (same ? 0 : 1) + (cpha ? 1 : 0) + 1)});
    chk("cs_after_start", 32'(cs_n_o), 32'(gap ? 4'hF : sel_mask(sel)));
    chk("busy_after_start", 32'(ready_o), 32'd0);
    if (gap) begin
      repeat (h) @(posedge clk_i);
      #1;
      chk("cs_after_gap", 32'(cs_n_o), 32'(sel_mask(sel)));
    end
    if (abort_at >= 0) begin
      while (sv_k < abort_at && t < 2000) begin
        @(negedge clk_i);
        t++;
      end
      #2;
      reset_i = 1'b1;
      #1;
      chk("rst_cs", 32'(cs_n_o), 32'hF);
      chk("rst_sclk", 32'(sclk_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_done", 32'(done_tick_o), 32'd0);
      chk("rst_dout", 32'(dout_o), 32'd0);
      chk("rst_mosi", 32'(mosi_o), 32'd0);
      sbq.delete();
      sv_active = 1'b0;
      m_held = 1'b0;
      @(negedge clk_i);
      reset_i = 1'b0;
      return;
    end
    m_held = hold;
    m_idx  = sel;
    @(negedge clk_i);
    wait_ready();
    chk("done_seen", 32'(sbq.size()), 32'd0);
    chk("cs_idle", 32'(cs_n_o), 32'(hold ? sel_mask(sel) : 4'hF));
    chk("sclk_idle", 32'(sclk_o), 32'(cpol));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_cs", 32'(cs_n_o), 32'hF);
    chk("reset_sclk", 32'(sclk_o), 32'd0);
    chk("reset_mosi", 32'(mosi_o), 32'd0);
    chk("reset_done", 32'(done_tick_o), 32'd0);
    chk("reset_dout", 32'(dout_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    xfer(8'hA5, 8'h3C, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    xfer(8'h81, 8'h5A, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    xfer(8'h81, 8'hC3, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    xfer(8'h81, 8'h7E, 1, 3, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    xfer(8'h01, 8'h80, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    xfer(8'hD2, 8'h11, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    xfer(8'h4B, 8'hE7, 1, 2, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    xfer(8'h96, 8'h2D, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    xfer(8'h33, 8'hCC, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    xfer(8'h6A, 8'h95, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    xfer(8'hF0, 8'h0F, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    xfer(8'hA5, 8'h3C, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    xfer(8'h5C, 8'hB1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 40; i++)
      xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), -1);
    xfer(8'h3E, 8'hD4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
